// File: rtl/timestamper_pulse_writer.sv
// timestamper_pulse_writer
//   Packs timestamped photon events into 32-bit words and writes them into a
//   dual-port BRAM ring buffer (port A). A header word is inserted on every frame
//   tick. The committed write pointer is published on pulses_addr for the PPC,
//   which treats every word below it as valid.
// Ports
//   user_clk     sole clock
//   user_rst_n   asynchronous reset, active low
//   enable       software run enable (synchronous)
//   sec_tick     one-cycle frame boundary strobe
//   evt_valid    event present
//   evt_ready    event accepted when evt_valid && evt_ready
//   evt_chan     event channel id
//   evt_ts       event timestamp
//   bram_we      BRAM port-A write strobe
//   bram_addr    BRAM port-A word address
//   bram_din     BRAM port-A write data
//   pulses_addr  {lap, zeros, next write address}
module timestamper_pulse_writer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CH_W   = 8,
    parameter int unsigned TS_W   = 21
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic              enable,
    input  logic              sec_tick,
    input  logic              evt_valid,
    output logic              evt_ready,
    input  logic [CH_W-1:0]   evt_chan,
    input  logic [TS_W-1:0]   evt_ts,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    output logic [31:0]       pulses_addr
);

    if (CH_W + TS_W > 30) begin : g_bad_width
        $error("timestamper_pulse_writer: CH_W + TS_W must not exceed 30");
    end

    localparam logic [1:0] S_OFF = 2'd0;
    localparam logic [1:0] S_RUN = 2'd1;
    localparam logic [1:0] S_HDR = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              lap_q, lap_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              tick_pend_q, tick_pend_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [31:0]       bram_din_q, bram_din_d;
    logic [31:0]       pulses_addr_q, pulses_addr_d;

    logic        evt_accept;
    logic        write_req;
    logic [31:0] evt_word;

    assign evt_ready  = (state_q == S_RUN) && !tick_pend_q && enable;
    assign evt_accept = evt_valid && evt_ready;
    assign write_req  = evt_accept || (state_q == S_HDR);

    always_comb begin
        evt_word                    = '0;
        evt_word[TS_W-1:0]          = evt_ts;
        evt_word[TS_W +: CH_W]      = evt_chan;
    end

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        lap_d         = lap_q;
        frame_cnt_d   = frame_cnt_q;
        tick_pend_d   = tick_pend_q;
        bram_we_d     = write_req;
        bram_addr_d   = bram_addr_q;
        bram_din_d    = bram_din_q;
        pulses_addr_d = pulses_addr_q;

        // Pointer trails the write strobe by one cycle so it only covers committed words.
        if (bram_we_q) begin
            pulses_addr_d                = '0;
            pulses_addr_d[31]            = lap_q;
            pulses_addr_d[ADDR_W-1:0]    = wr_addr_q;
        end

        if (write_req) begin
            bram_addr_d = wr_addr_q;
            bram_din_d  = (state_q == S_HDR) ? {2'b11, 14'h0, frame_cnt_q} : evt_word;
            wr_addr_d   = wr_addr_q + 1'b1;
            if (wr_addr_q == '1) begin
                lap_d = ~lap_q;
            end
        end

        case (state_q)
            S_OFF: begin
                if (enable) begin
                    state_d       = S_RUN;
                    wr_addr_d     = '0;
                    lap_d         = 1'b0;
                    frame_cnt_d   = '0;
                    tick_pend_d   = 1'b1;   // first word of a run is always a header
                    pulses_addr_d = '0;
                end
            end
            S_RUN: begin
                if (sec_tick) begin
                    tick_pend_d = 1'b1;
                end
                if (!enable) begin
                    state_d = S_OFF;
                end else if (tick_pend_q || sec_tick) begin
                    // Jumping straight on the tick keeps evt_ready low for one cycle only.
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                // A tick arriving here merges into the header being written.
                tick_pend_d = 1'b0;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = enable ? S_RUN : S_OFF;
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q       <= S_OFF;
            wr_addr_q     <= '0;
            lap_q         <= 1'b0;
            frame_cnt_q   <= '0;
            tick_pend_q   <= 1'b0;
            bram_we_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_din_q    <= '0;
            pulses_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            lap_q         <= lap_d;
            frame_cnt_q   <= frame_cnt_d;
            tick_pend_q   <= tick_pend_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            pulses_addr_q <= pulses_addr_d;
        end
    end

    assign bram_we     = bram_we_q;
    assign bram_addr   = bram_addr_q;
    assign bram_din    = bram_din_q;
    assign pulses_addr = pulses_addr_q;

endmodule

// File: tb/tb_timestamper_pulse_writer.sv
// Bench for timestamper_pulse_writer with a 16-word ring (ADDR_W=4).
module tb_timestamper_pulse_writer;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned TS_W   = 21;
    localparam int DEPTH = 16;

    logic              user_clk;
    logic              user_rst_n;
    logic              enable;
    logic              sec_tick;
    logic              evt_valid;
    logic              evt_ready;
    logic [CH_W-1:0]   evt_chan;
    logic [TS_W-1:0]   evt_ts;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;
    logic [31:0]       pulses_addr;

    timestamper_pulse_writer #(
        .ADDR_W (ADDR_W),
        .CH_W   (CH_W),
        .TS_W   (TS_W)
    ) dut (
        .user_clk    (user_clk),
        .user_rst_n  (user_rst_n),
        .enable      (enable),
        .sec_tick    (sec_tick),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_chan    (evt_chan),
        .evt_ts      (evt_ts),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .pulses_addr (pulses_addr)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: writer mode (0 off, 1 running, 2 header slot), owed header,
    // next ring slot, lap and frame number, plus the outputs expected after the next edge.
    int          m_mode;
    bit          m_pend;
    int          m_addr;
    bit          m_lap;
    int          m_frame;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_din;
    logic [31:0] e_ptr;
    logic        last_ready;
    logic [31:0] seen [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pend  = 0;
        m_addr  = 0;
        m_lap   = 0;
        m_frame = 0;
        e_we    = 0;
        e_addr  = 0;
        e_din   = 0;
        e_ptr   = 0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic en, input logic tk, input logic vl,
                         input logic [7:0] ch, input logic [20:0] ts);
        logic        exp_rdy;
        logic        acc;
        logic        wr;
        logic [31:0] n_ptr;
        logic [31:0] word;
        chk("bram_we", {31'd0, bram_we}, {31'd0, e_we});
        chk("bram_addr", {28'd0, bram_addr}, e_addr);
        chk("bram_din", bram_din, e_din);
        chk("pulses_addr", pulses_addr, e_ptr);
        if (bram_we) seen[bram_addr] = bram_din;

        enable    = en;
        sec_tick  = tk;
        evt_valid = vl;
        evt_chan  = ch;
        evt_ts    = ts;
        #1;
        exp_rdy = (m_mode == 1) && !m_pend && en;
        chk("evt_ready", {31'd0, evt_ready}, {31'd0, exp_rdy});
        last_ready = evt_ready;

        acc   = vl && exp_rdy;
        wr    = acc || (m_mode == 2);
        n_ptr = e_we ? ((32'(m_lap) << 31) | 32'(m_addr)) : e_ptr;
        e_we  = wr;
        if (wr) begin
            word = 32'h0;
            word[20:0]  = ts;
            word[28:21] = ch;
            e_addr = 32'(m_addr);
            e_din  = (m_mode == 2) ? (32'hC000_0000 | 32'(m_frame)) : word;
            m_addr = m_addr + 1;
            if (m_addr == DEPTH) begin
                m_addr = 0;
                m_lap  = !m_lap;
            end
        end
        if (m_mode == 0) begin
            if (en) begin
                m_mode = 1; m_addr = 0; m_lap = 0; m_frame = 0; m_pend = 1; n_ptr = 0;
            end
        end else if (m_mode == 1) begin
            if (tk) m_pend = 1;
            if (!en) m_mode = 0;
            else if (m_pend) m_mode = 2;
        end else begin
            m_pend  = 0;
            m_frame = (m_frame + 1) % 65536;
            m_mode  = en ? 1 : 0;
        end
        e_ptr = n_ptr;
        @(negedge user_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 8'h0, 21'h0);
    endtask

    initial begin
        user_rst_n = 1'b0;
        enable     = 1'b0;
        sec_tick   = 1'b0;
        evt_valid  = 1'b0;
        evt_chan   = '0;
        evt_ts     = '0;
        last_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) seen[i] = 32'hDEAD_BEEF;
        model_reset();
        #3;
        chk("rst_we", {31'd0, bram_we}, 32'd0);
        chk("rst_addr", {28'd0, bram_addr}, 32'd0);
        chk("rst_din", bram_din, 32'd0);
        chk("rst_ptr", pulses_addr, 32'd0);
        chk("rst_ready", {31'd0, evt_ready}, 32'd0);
        @(negedge user_clk);
        user_rst_n = 1'b1;

        // First header after enable.
        idle(3);
        chk("t1_we", {31'd0, bram_we}, 32'd1);
        chk("t1_addr", {28'd0, bram_addr}, 32'd0);
        chk("t1_din", bram_din, 32'hC000_0000);
        idle(1);
        chk("t1_ptr", pulses_addr, 32'd1);

        // Back-to-back events.
        cycle(1'b1, 1'b0, 1'b1, 8'd5, 21'h1000);
        cycle(1'b1, 1'b0, 1'b1, 8'd6, 21'h1001);
        cycle(1'b1, 1'b0, 1'b1, 8'd7, 21'h1002);
        idle(2);
        chk("t2_w1", seen[1], 32'h00A0_1000);
        chk("t2_w2", seen[2], 32'h00C0_1001);
        chk("t2_w3", seen[3], 32'h00E0_1002);
        chk("t2_ptr", pulses_addr, 32'd4);

        // Tick coincident with an accept.
        cycle(1'b1, 1'b1, 1'b1, 8'd1, 21'h55);
        chk("t3_ready_acc", {31'd0, last_ready}, 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 8'd2, 21'h66);
        chk("t3_ready_low", {31'd0, last_ready}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'd0, 21'h0);
        chk("t3_ready_back", {31'd0, last_ready}, 32'd1);
        idle(2);
        chk("t3_evt", seen[4], 32'h0020_0055);
        chk("t3_hdr", seen[5], 32'hC000_0001);

        // Wrap: addrs 6..15 then 0.
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 1'b1, 8'(i), 21'(i + 100));
        idle(2);
        chk("t4_wrap_word", seen[0], 32'h0140_006E);
        chk("t4_ptr", pulses_addr, 32'h8000_0001);

        // Disable with events still offered.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'h3, 21'h7);
        chk("t5_off_we", {31'd0, bram_we}, 32'd0);
        chk("t5_frozen", pulses_addr, 32'h8000_0001);
        idle(3);
        chk("t5_hdr", bram_din, 32'hC000_0000);
        chk("t5_hdr_addr", {28'd0, bram_addr}, 32'd0);
        idle(1);
        chk("t5_ptr", pulses_addr, 32'd1);

        // Reset in the middle of a burst.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 8'hAA, 21'(i));
        @(posedge user_clk);
        #2;
        user_rst_n = 1'b0;
        #1;
        chk("t6_we", {31'd0, bram_we}, 32'd0);
        chk("t6_ptr", pulses_addr, 32'd0);
        model_reset();
        @(negedge user_clk);
        user_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 8'h1, 21'h1);
        chk("t6_quiet", {31'd0, bram_we}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 99) < 97), ($urandom_range(0, 99) < 6),
                  ($urandom_range(0, 99) < 65), 8'($urandom), 21'($urandom));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
